// File: rtl/full_adder_checker_if.sv
// Bundle between the full-adder checker and the adder under test: stimulus,
// adder response, sweep control and result reporting.
interface full_adder_checker_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             y;
    logic             x;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [2:0]       fail_vec;

    modport master (
        input  start, y, x,
        output a, b, c, busy, done, pass, err_cnt, fail_valid, fail_vec
    );

    modport slave (
        output start, y, x,
        input  a, b, c, busy, done, pass, err_cnt, fail_valid, fail_vec
    );
endinterface

// File: rtl/full_adder_checker.sv
// Exhaustive on-chip tester for a 1-bit full adder: steps a/b/c through all
// eight vectors, samples sum/carry after a settle window and reports results.
module full_adder_checker #(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    full_adder_checker_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state_reg, state_next;
    logic [2:0]       vec_reg, vec_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic [ERR_W-1:0] err_reg, err_next;
    logic             fail_valid_reg, fail_valid_next;
    logic [2:0]       fail_vec_reg, fail_vec_next;

    logic exp_y;
    logic exp_x;
    logic mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            vec_reg        <= '0;
            cnt_reg        <= '0;
            err_reg        <= '0;
            fail_valid_reg <= 1'b0;
            fail_vec_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            vec_reg        <= vec_next;
            cnt_reg        <= cnt_next;
            err_reg        <= err_next;
            fail_valid_reg <= fail_valid_next;
            fail_vec_reg   <= fail_vec_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        vec_next        = vec_reg;
        cnt_next        = cnt_reg;
        err_next        = err_reg;
        fail_valid_next = fail_valid_reg;
        fail_vec_next   = fail_vec_reg;

        exp_y    = vec_reg[2] ^ vec_reg[1] ^ vec_reg[0];
        exp_x    = (vec_reg[2] & vec_reg[1]) | (vec_reg[2] & vec_reg[0]) |
                   (vec_reg[1] & vec_reg[0]);
        // A vector with both outputs wrong still counts as a single error.
        mismatch = (bus.y != exp_y) || (bus.x != exp_x);

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_next      = S_SETTLE;
                    vec_next        = '0;
                    cnt_next        = SETTLE_LOAD;
                    err_next        = '0;
                    fail_valid_next = 1'b0;
                    fail_vec_next   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_reg != ERR_MAX) begin
                        err_next = err_reg + 1'b1;
                    end
                    if (!fail_valid_reg) begin
                        fail_valid_next = 1'b1;
                        fail_vec_next   = vec_reg;
                    end
                end
                if (vec_reg == 3'd7) begin
                    state_next = S_DONE;
                end else begin
                    vec_next   = vec_reg + 3'd1;
                    cnt_next   = SETTLE_LOAD;
                    state_next = S_SETTLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.a          = vec_reg[2];
    assign bus.b          = vec_reg[1];
    assign bus.c          = vec_reg[0];
    assign bus.busy       = (state_reg == S_SETTLE) || (state_reg == S_CHECK);
    assign bus.done       = (state_reg == S_DONE);
    assign bus.pass       = (state_reg == S_DONE) && (err_reg == '0);
    assign bus.err_cnt    = err_reg;
    assign bus.fail_valid = fail_valid_reg;
    assign bus.fail_vec   = fail_vec_reg;
endmodule
